// File: rtl/javk_busio_pkg.sv
// Shared JAVK bus I/O definitions: the memory-mapped register addresses and the
// STATUS bit layout. Core tests and firmware headers use the same values.
package javk_busio_pkg;

  localparam logic [15:0] JAVK_IO_TXDATA = 16'hFF00;
  localparam logic [15:0] JAVK_IO_STATUS = 16'hFF01;
  localparam logic [15:0] JAVK_IO_CYC_LO = 16'hFF02;
  localparam logic [15:0] JAVK_IO_CYC_HI = 16'hFF03;

  localparam int STS_FULL    = 0;
  localparam int STS_EMPTY   = 1;
  localparam int STS_OVF     = 2;
  localparam int STS_CNT_LSB = 4;

  // The count field is only 4 bits wide, so a 16-deep FIFO reports 15 when full.
  function automatic logic [7:0] pack_status(input logic full, input logic empty,
                                             input logic ovf, input logic [4:0] cnt);
    logic [7:0] s;
    s = '0;
    s[STS_FULL]  = full;
    s[STS_EMPTY] = empty;
    s[STS_OVF]   = ovf;
    s[STS_CNT_LSB +: 4] = cnt[4] ? 4'hF : cnt[3:0];
    return s;
  endfunction

endpackage

// File: rtl/javk_fifo.sv
// Synchronous FIFO for the TX port. A push into a full FIFO is dropped even when
// a pop happens on the same edge. The head reads as zero while the FIFO is empty.
module javk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage arrays carry no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/javk_busio.sv
// JAVK bus slave: RAM, TX FIFO port with sticky overflow status, optional cycle
// counter enabled by `JAVK_BUSIO_CYCCNT_EN (LO read snapshots HI for atomic reads).
module javk_busio
  import javk_busio_pkg::*;
#(
  parameter int         RAM_AW     = 15,
  parameter int         TXF_DEPTH  = 8,
  parameter logic [7:0] UNMAP_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrbus,
  input  logic        rw,
  inout  wire  [7:0]  databus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [7:0] ram [2**RAM_AW];
  logic       ram_sel, txd_sel, sts_sel;
  logic       wr_txd, wr_sts;
  logic       txf_full, txf_empty, txf_pop;
  logic [$clog2(TXF_DEPTH):0] txf_count;
  logic       ovf;
  logic [7:0] rdata;

  assign ram_sel = ((32'(addrbus) >> RAM_AW) == 32'd0);
  assign txd_sel = (addrbus == JAVK_IO_TXDATA);
  assign sts_sel = (addrbus == JAVK_IO_STATUS);
  assign wr_txd  = ~rw & txd_sel;
  assign wr_sts  = ~rw & sts_sel;

  always_ff @(posedge clk) begin
    if (~rw && ram_sel) ram[addrbus[RAM_AW-1:0]] <= databus;
  end

  javk_fifo #(.WIDTH(8), .DEPTH(TXF_DEPTH)) u_txf (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txd),
    .pop   (txf_pop),
    .wdata (databus),
    .rdata (tx_data),
    .full  (txf_full),
    .empty (txf_empty),
    .count (txf_count)
  );

  assign tx_valid = ~txf_empty;
  assign txf_pop  = tx_valid & tx_ready;

  // A dropped push sets ovf; setting takes priority over a STATUS write clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   ovf <= 1'b0;
    else if (wr_txd & txf_full) ovf <= 1'b1;
    else if (wr_sts)            ovf <= 1'b0;
  end

`ifdef JAVK_BUSIO_CYCCNT_EN
  logic [15:0] cyc_cnt;
  logic [7:0]  cyc_shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 16'd1;
      if (rw && addrbus == JAVK_IO_CYC_LO) cyc_shadow <= cyc_cnt[15:8];
    end
  end
`endif

  // NOTE: rdata gets a default before any branch so no latch is inferred.
  always_comb begin
    rdata = UNMAP_DATA;
    if (ram_sel)      rdata = ram[addrbus[RAM_AW-1:0]];
    else if (sts_sel) rdata = pack_status(txf_full, txf_empty, ovf, 5'(txf_count));
`ifdef JAVK_BUSIO_CYCCNT_EN
    else if (addrbus == JAVK_IO_CYC_LO) rdata = cyc_count_lo();
    else if (addrbus == JAVK_IO_CYC_HI) rdata = cyc_shadow;
`endif
  end

`ifdef JAVK_BUSIO_CYCCNT_EN
  function automatic logic [7:0] cyc_count_lo();
    return cyc_cnt[7:0];
  endfunction
`endif

  assign databus = (rw && rst) ? rdata : 8'bz;

endmodule

// File: tb/tb_javk_busio.sv
// Directed bench for javk_busio: RAM access, TX FIFO flow/overflow, reset, and the
// optional cycle counter when `JAVK_BUSIO_CYCCNT_EN is defined.
module tb_javk_busio;
  import javk_busio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addrbus = 16'hFFFF;
  logic        rw = 1'b1;
  logic [7:0]  tb_drv = 8'h00;
  logic        tb_oe = 1'b0;
  wire  [7:0]  databus;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  assign databus = tb_oe ? tb_drv : 8'bz;

  always #5 clk = ~clk;

  javk_busio dut (
    .clk      (clk),
    .rst      (rst),
    .addrbus  (addrbus),
    .rw       (rw),
    .databus  (databus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rw      = 1'b1;
    tb_oe   = 1'b0;
    addrbus = 16'hFFFF;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addrbus = a; rw = 1'b0; tb_drv = d; tb_oe = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    addrbus = a; rw = 1'b1; tb_oe = 1'b0;
    #1 check(tag, 16'(databus), 16'(exp));
    @(posedge clk); #1;
    idle();
  endtask

  task automatic drain(input string tag, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      check({tag, "_valid"}, 16'(tx_valid), 16'd1);
      check({tag, "_data"}, 16'(tx_data), 16'(first + 8'(i)));
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 16'(tx_valid), 16'd0);
    check("rst_data", 16'(tx_data), 16'h00);
    @(negedge clk);
    rst = 1'b1;

    // 1: RAM and decode
    wr(16'h0123, 8'h5A);
    rdchk("ram_rd", 16'h0123, 8'h5A);
    rdchk("unmap_rd", 16'h9000, 8'hFF);
    rdchk("txdata_rd", JAVK_IO_TXDATA, 8'hFF);
    wr(16'h7FFF, 8'h3C);
    rdchk("ram_top", 16'h7FFF, 8'h3C);
    wr(16'h0000, 8'h11);
    wr(16'h8000, 8'h22);
    rdchk("no_alias", 16'h0000, 8'h11);
    @(negedge clk);
    addrbus = 16'h9000; rw = 1'b0; tb_drv = 8'h00; tb_oe = 1'b1;
    #1 check("wr_release", 16'(databus), 16'h00);
    @(posedge clk); #1;
    idle();

    // 2: two pushes, then drain
    check("empty_valid", 16'(tx_valid), 16'd0);
    rdchk("sts_empty", JAVK_IO_STATUS, 8'h02);
    wr(JAVK_IO_TXDATA, 8'h41);
    check("push_valid", 16'(tx_valid), 16'd1);
    check("push_head", 16'(tx_data), 16'h41);
    wr(JAVK_IO_TXDATA, 8'h42);
    check("hold_head", 16'(tx_data), 16'h41);
    rdchk("sts_two", JAVK_IO_STATUS, 8'h20);
    drain("t2", 8'h41, 2);
    check("t2_done", 16'(tx_valid), 16'd0);
    rdchk("sts_t2", JAVK_IO_STATUS, 8'h02);

    // 3: overflow
    for (int i = 0; i < 9; i++) wr(JAVK_IO_TXDATA, 8'(i));
    rdchk("sts_ovf", JAVK_IO_STATUS, 8'h85);
    drain("t3", 8'h00, 8);
    rdchk("sts_drained", JAVK_IO_STATUS, 8'h06);
    wr(JAVK_IO_STATUS, 8'h00);
    rdchk("sts_clr", JAVK_IO_STATUS, 8'h02);

    // 4: push+pop on a full FIFO, then on a one-entry FIFO
    for (int i = 0; i < 8; i++) wr(JAVK_IO_TXDATA, 8'(8'h10 + 8'(i)));
    rdchk("sts_full", JAVK_IO_STATUS, 8'h81);
    @(negedge clk);
    addrbus = JAVK_IO_TXDATA; rw = 1'b0; tb_drv = 8'h99; tb_oe = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    idle(); tx_ready = 1'b0;
    rdchk("sts_full_pp", JAVK_IO_STATUS, 8'h74);
    drain("t4a", 8'h11, 7);
    wr(JAVK_IO_STATUS, 8'h00);
    wr(JAVK_IO_TXDATA, 8'h21);
    @(negedge clk);
    addrbus = JAVK_IO_TXDATA; rw = 1'b0; tb_drv = 8'h22; tb_oe = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    idle(); tx_ready = 1'b0;
    rdchk("sts_one_pp", JAVK_IO_STATUS, 8'h10);
    drain("t4b", 8'h22, 1);

    // 5: reset mid-transfer
    for (int i = 0; i < 3; i++) wr(JAVK_IO_TXDATA, 8'(8'h30 + 8'(i)));
    check("pre_rst_valid", 16'(tx_valid), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", 16'(tx_valid), 16'd0);
    check("rst_mid_data", 16'(tx_data), 16'h00);
    @(negedge clk);
    rst = 1'b1;
    rdchk("sts_after_rst", JAVK_IO_STATUS, 8'h02);
    rdchk("ram_keep", 16'h0123, 8'h5A);

`ifdef JAVK_BUSIO_CYCCNT_EN
    // 6: cycle counter, atomic LO/HI reads and wrap
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (16'h1FF) @(posedge clk);
    #1;
    rdchk("cyc_lo", JAVK_IO_CYC_LO, 8'hFF);
    rdchk("cyc_hi", JAVK_IO_CYC_HI, 8'h01);
    repeat (65535 - 16'h201) @(posedge clk);
    #1;
    rdchk("cyc_lo_top", JAVK_IO_CYC_LO, 8'hFF);
    rdchk("cyc_hi_top", JAVK_IO_CYC_HI, 8'hFF);
    rdchk("cyc_lo_wrap", JAVK_IO_CYC_LO, 8'h01);
    rdchk("cyc_hi_wrap", JAVK_IO_CYC_HI, 8'h00);
`else
    rdchk("cyc_lo_unmap", JAVK_IO_CYC_LO, 8'hFF);
    rdchk("cyc_hi_unmap", JAVK_IO_CYC_HI, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
